spi_control_fsm: RTL
====================

# spi_control_fsm

Transaction controller for the SPI memory slave. It consumes the conditioned chip-select and SCLK rising-edge pulses, tracks bit counts, and inspects the byte assembled in the serial-in/parallel-out shift register. It drives the shift register's parallel load, the address latch enable, the data-memory write enable and the MISO tri-state buffer enable. It sits between the input conditioners and the shift register / address latch / data memory.

## Interface
- `width`, default 8: bits per SPI byte. Address is `width-1` bits followed by a 1-bit R/W flag.
- `clk` in 1: FPGA clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `cs_n` in 1: conditioned chip select, active low.
- `sclk_rise` in 1: one-`clk` pulse per SCLK rising edge. It is the same signal that drives the shift register's `peripheralClkEdge`.
- `sr_data` in `width`: shift register parallel contents.
- `sr_load` out 1: shift register parallel-load strobe.
- `addr_we` out 1: address latch enable.
- `dm_we` out 1: data memory write enable.
- `miso_buff` out 1: MISO output buffer enable.
- `state` out 3: current state encoding, for debug.

## Operation
- Moore machine. All outputs decode from the state register only.
- Internal `$clog2(width)+1`-bit bit counter.
- States:
  - IDLE: counter cleared. `cs_n`=0 → GET_ADDR. `sclk_rise` is ignored in IDLE.
  - GET_ADDR: counter increments on each `sclk_rise`. When the counter reaches `width` → LATCH_ADDR, and the counter clears.
  - LATCH_ADDR: `addr_we`=1 for exactly one cycle. `sr_data[0]`=1 (read) → READ_LOAD; otherwise → WRITE_RECV.
  - READ_LOAD: `sr_load`=1 for exactly one cycle → READ_SHIFT.
  - READ_SHIFT: `miso_buff`=1. Counter increments on `sclk_rise`. On reaching `width` → DONE.
  - WRITE_RECV: counter increments on `sclk_rise`. On reaching `width` → WRITE_MEM.
  - WRITE_MEM: `dm_we`=1 for exactly one cycle → DONE.
  - DONE: all strobes 0. `sclk_rise` is ignored. Wait for `cs_n`=1.
- `cs_n`=1 in any non-IDLE state → IDLE next cycle and the counter clears. This takes priority over every other transition, including a simultaneous terminal `sclk_rise`. An aborted write never asserts `dm_we`.
- Exactly one transaction per CS assertion. Further bytes while in DONE are discarded.

## Timing
- Reset: state IDLE, counter 0. `sr_load`, `addr_we`, `dm_we` and `miso_buff` are all 0, and `state`=0.
- Reset asserted mid-transaction returns to IDLE on the next edge, regardless of `cs_n`. After reset releases with `cs_n` still low, the FSM re-enters GET_ADDR on the following cycle.
- LATCH_ADDR is entered the cycle after the clk edge that registered the `width`-th address bit. By then the shift register already holds the full byte, so `sr_data` is valid in LATCH_ADDR.
- Write path: `dm_we` is high the cycle after the `width`-th data `sclk_rise`.
- Read path: `sr_load` is high 2 cycles after the `width`-th address `sclk_rise`. Memory read data must be valid combinationally from the latched address by then.
  - The master must leave at least 3 `clk` cycles between the last address SCLK rise and the first data SCLK rise.
- `miso_buff` rises the cycle after `sr_load` and falls the cycle after the `width`-th read `sclk_rise`, or the cycle after `cs_n` rises.
- `cs_n` falling to GET_ADDR takes 1 cycle. `sclk_rise` in that same cycle is not counted.

## Structure
- Package `spi_pkg` holds:
  - State encoding constants: IDLE=0, GET_ADDR=1, LATCH_ADDR=2, READ_LOAD=3, READ_SHIFT=4, WRITE_RECV=5, WRITE_MEM=6, DONE=7.
  - `RW_READ`=1.
  - The default byte width.
- Sub-module `spi_bit_counter`: inputs `clear` and `inc`, outputs `count` and a `full` flag (count==`width`). Shared by all counting states.

## Test plan
- Write: `cs_n`=0, shift address byte 0x2A (addr 0x15, W), then data byte 0xC3 → `addr_we` pulses once, then `dm_we` pulses once, one cycle after the 16th `sclk_rise`. `state` ends at DONE (7).
- Read: address byte 0x2B (addr 0x15, R) → `addr_we`, then `sr_load` 1 cycle later. `miso_buff` stays high for exactly 8 `sclk_rise` pulses, then DONE. `dm_we` never asserts.
- Abort in address phase: `cs_n`=1 after 5 rises → IDLE next cycle. No strobes. The next transaction counts from 0.
- Abort coincident with the 8th write-data `sclk_rise` → IDLE, `dm_we` stays 0.
- Reset asserted during READ_SHIFT → all outputs 0 the next cycle with `state`=0. `cs_n` still low → GET_ADDR the cycle after reset deasserts.
- Extra bytes in DONE: 8 more rises → no strobes. `cs_n`=1 → IDLE. An immediate new write completes normally.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI memory slave transaction controller.
//   DEFAULT_WIDTH : bits per SPI byte (7-bit address + R/W flag by default)
//   RW_READ       : value of the R/W flag (address byte bit 0) that selects a read
//   spiStateT     : controller state encoding, also exported on the debug port
package spi_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   localparam logic RW_READ = 1'b1;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      GET_ADDR   = 3'd1,
      LATCH_ADDR = 3'd2,
      READ_LOAD  = 3'd3,
      READ_SHIFT = 3'd4,
      WRITE_RECV = 3'd5,
      WRITE_MEM  = 3'd6,
      DONE       = 3'd7
   } spiStateT;

   // States in which sclk_rise advances the bit counter.
   function automatic logic isCounting(input spiStateT s);
      return (s == GET_ADDR) || (s == READ_SHIFT) || (s == WRITE_RECV);
   endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Bit counter shared by the address, read and write phases.
//   clk, reset : clock and synchronous active-high reset
//   clear      : zero the count (wins over inc)
//   inc        : advance the count by one
//   count      : current number of bits seen in this phase
//   full       : count == width
module spi_bit_counter
   import spi_pkg::*;
#(
   parameter  int unsigned width = DEFAULT_WIDTH,
   localparam int unsigned CntW  = $clog2(width) + 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clear,
   input  logic            inc,
   output logic [CntW-1:0] count,
   output logic            full
);

   // Count register.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (inc) begin
         count <= count + CntW'(1);
      end
   end

   assign full = (count == CntW'(width));

endmodule

// File: rtl/spi_control_fsm.sv
// Transaction controller for the SPI memory slave. Counts the address byte,
// latches it, then either loads the shift register and enables MISO for a
// read byte, or receives a data byte and strobes the data-memory write.
// One transaction per chip-select assertion; a rising cs_n aborts at once.
//   clk, reset : clock and synchronous active-high reset
//   cs_n       : conditioned chip select, active low
//   sclk_rise  : one-clk pulse per SCLK rising edge
//   sr_data    : shift register parallel contents (bit 0 = R/W flag)
//   sr_load    : shift register parallel-load strobe
//   addr_we    : address latch enable
//   dm_we      : data memory write enable
//   miso_buff  : MISO tri-state buffer enable
//   state      : current state encoding, for debug
module spi_control_fsm
   import spi_pkg::*;
#(
   parameter  int unsigned width = DEFAULT_WIDTH,
   localparam int unsigned CntW  = $clog2(width) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cs_n,
   input  logic             sclk_rise,
   input  logic [width-1:0] sr_data,
   output logic             sr_load,
   output logic             addr_we,
   output logic             dm_we,
   output logic             miso_buff,
   output logic [2:0]       state
);

   spiStateT        stateQ;
   spiStateT        stateNext;
   logic            cntClear;
   logic            cntInc;
   logic            cntFull;
   logic [CntW-1:0] cntValue;
   logic            bitDone;
   logic            srLoadNext;
   logic            addrWeNext;
   logic            dmWeNext;
   logic            misoBuffNext;

   // Only the R/W flag is inspected here; the address bits go to the latch.
   logic unusedSrData;
   assign unusedSrData = ^sr_data[width-1:1];

   spi_bit_counter #(
      .width (width)
   ) u_bitCounter (
      .clk   (clk),
      .reset (reset),
      .clear (cntClear),
      .inc   (cntInc),
      .count (cntValue),
      .full  (cntFull)
   );

   // The width-th bit finishes a phase on the same edge that registers it,
   // so the next state is entered one cycle after that sclk_rise.
   assign bitDone = cntFull || (sclk_rise && (cntValue == CntW'(width - 1)));

   // State and output registers; outputs are decoded from the next state so
   // they line up exactly with the state they belong to.
   always_ff @(posedge clk) begin
      if (reset) begin
         stateQ    <= IDLE;
         sr_load   <= 1'b0;
         addr_we   <= 1'b0;
         dm_we     <= 1'b0;
         miso_buff <= 1'b0;
      end else begin
         stateQ    <= stateNext;
         sr_load   <= srLoadNext;
         addr_we   <= addrWeNext;
         dm_we     <= dmWeNext;
         miso_buff <= misoBuffNext;
      end
   end

   // Next-state and counter control.
   always_comb begin
      stateNext = stateQ;
      cntClear  = 1'b0;
      cntInc    = isCounting(stateQ) && sclk_rise;

      unique case (stateQ)
         IDLE: begin
            cntClear = 1'b1;
            if (!cs_n) begin
               stateNext = GET_ADDR;
            end
         end
         GET_ADDR: begin
            if (bitDone) begin
               stateNext = LATCH_ADDR;
               cntClear  = 1'b1;
            end
         end
         LATCH_ADDR: begin
            cntClear  = 1'b1;
            stateNext = (sr_data[0] == RW_READ) ? READ_LOAD : WRITE_RECV;
         end
         READ_LOAD: begin
            cntClear  = 1'b1;
            stateNext = READ_SHIFT;
         end
         READ_SHIFT: begin
            if (bitDone) begin
               stateNext = DONE;
               cntClear  = 1'b1;
            end
         end
         WRITE_RECV: begin
            if (bitDone) begin
               stateNext = WRITE_MEM;
               cntClear  = 1'b1;
            end
         end
         WRITE_MEM: begin
            cntClear  = 1'b1;
            stateNext = DONE;
         end
         DONE: begin
            cntClear = 1'b1;
         end
         default: begin
            cntClear  = 1'b1;
            stateNext = IDLE;
         end
      endcase

      // Chip-select release aborts everything, including a terminal bit.
      if (cs_n && (stateQ != IDLE)) begin
         stateNext = IDLE;
         cntClear  = 1'b1;
         cntInc    = 1'b0;
      end
   end

   // Strobe decode for the upcoming state.
   always_comb begin
      srLoadNext   = 1'b0;
      addrWeNext   = 1'b0;
      dmWeNext     = 1'b0;
      misoBuffNext = 1'b0;
      unique case (stateNext)
         LATCH_ADDR: addrWeNext   = 1'b1;
         READ_LOAD:  srLoadNext   = 1'b1;
         READ_SHIFT: misoBuffNext = 1'b1;
         WRITE_MEM:  dmWeNext     = 1'b1;
         default:    ;
      endcase
   end

   assign state = 3'(stateQ);

endmodule
